simon_sequencer: RTL and testbench

SIMON_SEQUENCER -- requirements
Module: simon_sequencer

---
 rtl/simon_sequencer.sv | 191 +++++++++++++++++++
 tb/tb_simon_sequencer.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/simon_sequencer.sv
// rtl/simon_sequencer.sv - Simon step store, LED playback and press checker; SIMON_TIMEOUT_EN adds an input-phase timeout
// The IDLE/RUN/OVER/WIN state type lives in simon_pkg, shared with the game controller.
package simon_pkg;
    typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, OVER = 2'd2, WIN = 2'd3} state_t;
endpackage

module simon_sequencer
    import simon_pkg::*;
#(
    parameter int MAX_LEN       = 16,
    parameter int ON_TICKS      = 5_000_000,
    parameter int OFF_TICKS     = 2_500_000,
    parameter int TIMEOUT_TICKS = 50_000_000
) (
    input  logic       clk,
    input  logic       reset,
    input  state_t     state,
    input  logic [1:0] rnd,
    input  logic       btn_valid,
    input  logic [1:0] btn_code,
    output logic [3:0] led,
    output logic [4:0] level,
    output logic       input_phase,
    output logic       round_done,
    output logic       mismatch,
    output logic       seq_full
);
    localparam int AW   = $clog2(MAX_LEN);
    localparam int TMAX = (ON_TICKS > OFF_TICKS) ? ON_TICKS : OFF_TICKS;
    localparam int TW   = $clog2(TMAX + 1);

    if (MAX_LEN < 2 || MAX_LEN > 31 || ON_TICKS < 1 || OFF_TICKS < 1 || TIMEOUT_TICKS < 1) begin : g_bad_params
        $error("simon_sequencer: parameter out of range");
    end

    typedef enum logic [2:0] {S_IDLE, S_APPEND, S_PLAY_ON, S_PLAY_OFF, S_INPUT, S_DONE} fsm_t;

    fsm_t          fsm_q, fsm_d;
    logic [4:0]    len_q, len_d;
    logic [4:0]    idx_q, idx_d;
    logic [TW-1:0] timer_q, timer_d;
    logic          round_done_q, round_done_d;
    logic          mismatch_q, mismatch_d;
    logic          seq_full_q, seq_full_d;
    logic [1:0]    mem_q [MAX_LEN];
    logic [1:0]    cur_step;
    logic          last_step;
    logic          running;
`ifdef SIMON_TIMEOUT_EN
    localparam int OW = $clog2(TIMEOUT_TICKS + 1);
    logic [OW-1:0] idle_q, idle_d;
`endif

    assign running   = (state == RUN);
    assign cur_step  = mem_q[idx_q[AW-1:0]];
    assign last_step = (idx_q == len_q - 5'd1);

    // Entries at or beyond len are never read, so the array needs no reset.
    always_ff @(posedge clk) begin
        if (!reset && running && fsm_q == S_APPEND) begin
            mem_q[len_q[AW-1:0]] <= rnd;
        end
    end

    always_comb begin
        fsm_d        = fsm_q;
        len_d        = len_q;
        idx_d        = idx_q;
        timer_d      = timer_q;
        round_done_d = 1'b0;
        mismatch_d   = 1'b0;
        seq_full_d   = 1'b0;
`ifdef SIMON_TIMEOUT_EN
        idle_d       = idle_q;
`endif
        if (!running) begin
            fsm_d   = S_IDLE;
            len_d   = '0;
            idx_d   = '0;
            timer_d = '0;
        end else begin
            case (fsm_q)
                S_IDLE: fsm_d = S_APPEND;
                S_APPEND: begin
                    len_d   = len_q + 5'd1;
                    idx_d   = '0;
                    timer_d = '0;
                    fsm_d   = S_PLAY_ON;
                end
                S_PLAY_ON: begin
                    if (timer_q == TW'(ON_TICKS - 1)) begin
                        timer_d = '0;
                        fsm_d   = S_PLAY_OFF;
                    end else begin
                        timer_d = timer_q + TW'(1);
                    end
                end
                S_PLAY_OFF: begin
                    if (timer_q == TW'(OFF_TICKS - 1)) begin
                        timer_d = '0;
                        if (last_step) begin
                            idx_d = '0;
                            fsm_d = S_INPUT;
`ifdef SIMON_TIMEOUT_EN
                            idle_d = '0;
`endif
                        end else begin
                            idx_d = idx_q + 5'd1;
                            fsm_d = S_PLAY_ON;
                        end
                    end else begin
                        timer_d = timer_q + TW'(1);
                    end
                end
                S_INPUT: begin
                    if (btn_valid) begin
`ifdef SIMON_TIMEOUT_EN
                        idle_d = '0;
`endif
                        if (btn_code != cur_step) begin
                            mismatch_d = 1'b1;
                            fsm_d      = S_DONE;
                        end else if (!last_step) begin
                            idx_d = idx_q + 5'd1;
                        end else if (len_q == 5'(MAX_LEN)) begin
                            seq_full_d = 1'b1;
                            fsm_d      = S_DONE;
                        end else begin
                            round_done_d = 1'b1;
                            fsm_d        = S_APPEND;
                        end
                    end
`ifdef SIMON_TIMEOUT_EN
                    else if (idle_q == OW'(TIMEOUT_TICKS - 1)) begin
                        mismatch_d = 1'b1;
                        fsm_d      = S_DONE;
                    end else begin
                        idle_d = idle_q + OW'(1);
                    end
`endif
                end
                S_DONE: fsm_d = S_DONE;
                default: fsm_d = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            fsm_q        <= S_IDLE;
            len_q        <= '0;
            idx_q        <= '0;
            timer_q      <= '0;
            round_done_q <= 1'b0;
            mismatch_q   <= 1'b0;
            seq_full_q   <= 1'b0;
`ifdef SIMON_TIMEOUT_EN
            idle_q       <= '0;
`endif
        end else begin
            fsm_q        <= fsm_d;
            len_q        <= len_d;
            idx_q        <= idx_d;
            timer_q      <= timer_d;
            round_done_q <= round_done_d;
            mismatch_q   <= mismatch_d;
            seq_full_q   <= seq_full_d;
`ifdef SIMON_TIMEOUT_EN
            idle_q       <= idle_d;
`endif
        end
    end

    // The display goes dark as soon as the game leaves RUN, not one edge later.
    always_comb begin
        led = 4'b0000;
        if (running) begin
            case (fsm_q)
                S_PLAY_ON: led = 4'b0001 << cur_step;
                S_INPUT:   if (btn_valid) led = 4'b0001 << btn_code;
                default:   led = 4'b0000;
            endcase
        end
    end

    assign input_phase = running && (fsm_q == S_INPUT);
    assign level       = len_q;
    assign round_done  = round_done_q;
    assign mismatch    = mismatch_q;
    assign seq_full    = seq_full_q;
endmodule

// File: tb/tb_simon_sequencer.sv
// tb/tb_simon_sequencer.sv - directed games against a queue-based playback model of simon_sequencer
module tb_simon_sequencer;
    import simon_pkg::*;

    localparam int MAX_LEN = 4, ON_TICKS = 4, OFF_TICKS = 2, TIMEOUT_TICKS = 20;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    state_t     st = IDLE;
    logic [1:0] rnd = 2'd0;
    logic       btn_valid = 1'b0;
    logic [1:0] btn_code = 2'd0;
    logic [3:0] led;
    logic [4:0] level;
    logic       input_phase, round_done, mismatch, seq_full;

    int n_checks = 0;
    int n_pass   = 0;
    bit chk_en   = 1'b0;
    int wi_n;
    int wi_lit [4];

    simon_sequencer #(
        .MAX_LEN(MAX_LEN), .ON_TICKS(ON_TICKS), .OFF_TICKS(OFF_TICKS), .TIMEOUT_TICKS(TIMEOUT_TICKS)
    ) dut (
        .clk(clk), .reset(reset), .state(st), .rnd(rnd), .btn_valid(btn_valid), .btn_code(btn_code),
        .led(led), .level(level), .input_phase(input_phase),
        .round_done(round_done), .mismatch(mismatch), .seq_full(seq_full)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    endtask

    // Model: the remembered sequence plus a queue holding every LED value of the upcoming playback.
    localparam int M_IDLE = 0, M_APPEND = 1, M_PLAY = 2, M_INPUT = 3, M_DONE = 4;
    int         mode = M_IDLE;
    logic [1:0] seq [$];
    logic [3:0] play [$];
    int         pos = 0;
    bit         p_rd = 1'b0, p_mm = 1'b0, p_sf = 1'b0;
`ifdef SIMON_TIMEOUT_EN
    int         idle = 0;
`endif

    initial begin : model
        logic [3:0] e_led;
        bit run;
        forever begin
            @(negedge clk);
            run   = (st == RUN);
            e_led = 4'b0000;
            if (run && mode == M_PLAY) e_led = play[0];
            else if (run && mode == M_INPUT && btn_valid) e_led = 4'b0001 << btn_code;
            if (chk_en) begin
                chk("led", led, e_led);
                chk("level", level, seq.size());
                chk("input_phase", input_phase, run && mode == M_INPUT);
                chk("round_done", round_done, p_rd);
                chk("mismatch", mismatch, p_mm);
                chk("seq_full", seq_full, p_sf);
            end
            // Inputs are stable from here to the next rising edge, so advance the model now.
            p_rd = 1'b0; p_mm = 1'b0; p_sf = 1'b0;
            if (reset || !run) begin
                seq.delete(); play.delete(); mode = M_IDLE;
            end else begin
                case (mode)
                    M_IDLE: mode = M_APPEND;
                    M_APPEND: begin
                        seq.push_back(rnd);
                        play.delete();
                        foreach (seq[k]) begin
                            repeat (ON_TICKS) play.push_back(4'b0001 << seq[k]);
                            repeat (OFF_TICKS) play.push_back(4'b0000);
                        end
                        mode = M_PLAY;
                    end
                    M_PLAY: begin
                        void'(play.pop_front());
                        if (play.size() == 0) begin
                            mode = M_INPUT; pos = 0;
`ifdef SIMON_TIMEOUT_EN
                            idle = 0;
`endif
                        end
                    end
                    M_INPUT: begin
                        if (btn_valid) begin
`ifdef SIMON_TIMEOUT_EN
                            idle = 0;
`endif
                            if (btn_code != seq[pos]) begin p_mm = 1'b1; mode = M_DONE; end
                            else if (pos < seq.size() - 1) pos++;
                            else if (seq.size() == MAX_LEN) begin p_sf = 1'b1; mode = M_DONE; end
                            else begin p_rd = 1'b1; mode = M_APPEND; end
                        end
`ifdef SIMON_TIMEOUT_EN
                        else begin
                            idle++;
                            if (idle == TIMEOUT_TICKS) begin p_mm = 1'b1; mode = M_DONE; end
                        end
`endif
                    end
                    default: mode = mode;
                endcase
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic press(input logic [1:0] c);
        btn_valid = 1'b1;
        btn_code  = c;
        tick();
        btn_valid = 1'b0;
    endtask

    task automatic wait_input(input int budget);
        wi_n = 0;
        for (int k = 0; k < 4; k++) wi_lit[k] = 0;
        while (!input_phase && wi_n < budget) begin
            for (int k = 0; k < 4; k++) if (led == (4'b0001 << k)) wi_lit[k]++;
            wi_n++;
            tick();
        end
        chk("wait_input", input_phase, 1);
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: got no finish, expected finish before time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin : stim
        logic [1:0] seq2 [4];
        int first, cnt;
        seq2 = '{2'd0, 2'd3, 2'd1, 2'd2};

        // Reset state
        tick(); chk_en = 1'b1; tick(); tick();
        chk("rst_led", led, 0);
        chk("rst_level", level, 0);
        chk("rst_input_phase", input_phase, 0);
        reset = 1'b0; tick();

        // Reset in the middle of playback
        st = RUN; rnd = 2'd2;
        tick(); tick(); tick();
        chk("mid_play_led", led, 4'b0100);
        reset = 1'b1; tick();
        chk("mid_reset_led", led, 0);
        chk("mid_reset_level", level, 0);
        reset = 1'b0;

        // Game 1: round 1 {2}, round 2 {2,1}, wrong second press
        wait_input(50);
        chk("r1_cycles_to_input", wi_n, 8);
        chk("r1_led2_cycles", wi_lit[2], 4);
        chk("r1_level", level, 1);
        rnd = 2'd1;
        press(2'd2);
        chk("r1_round_done", round_done, 1);
        wait_input(50);
        chk("r2_cycles_to_input", wi_n, 13);
        chk("r2_led2_cycles", wi_lit[2], 4);
        chk("r2_led1_cycles", wi_lit[1], 4);
        chk("r2_level", level, 2);
        press(2'd2);
        chk("r2_first_ok", mismatch, 0);
        press(2'd3);
        chk("r2_mismatch", mismatch, 1);
        chk("r2_done_input_phase", input_phase, 0);
        tick();
        chk("r2_mismatch_one_cycle", mismatch, 0);
        repeat (5) tick();
        chk("done_led", led, 0);
        chk("done_level", level, 2);
        press(2'd1);
        st = OVER; tick();
        chk("over_level", level, 0);
        st = IDLE; tick();

        // Game 2: four correct rounds with a stray press during playback
        rnd = seq2[0]; st = RUN; tick();
        for (int r = 0; r < 4; r++) begin
            if (r == 1) begin tick(); tick(); press(2'd3); end
            wait_input(100);
            for (int k = 0; k <= r; k++) begin
                if (k == r && r < 3) rnd = seq2[r+1];
                press(seq2[k]);
            end
            if (r < 3) chk("g2_round_done", round_done, 1);
            else begin
                chk("g2_seq_full", seq_full, 1);
                chk("g2_last_no_round_done", round_done, 0);
                chk("g2_full_level", level, 4);
            end
        end
        repeat (10) tick();
        chk("g2_no_fifth_level", level, 4);
        chk("g2_no_fifth_input", input_phase, 0);
        st = WIN; tick();
        chk("win_level", level, 0);
        st = IDLE; tick();

        // Game 3: input-phase idling
        rnd = 2'd0; st = RUN; tick();
        wait_input(100);
        press(2'd0);
        wait_input(100);
        repeat (19) tick();
        press(2'd0);
        chk("g3_press_restart", mismatch, 0);
        chk("g3_still_input", input_phase, 1);
        first = -1; cnt = 0;
        for (int i = 0; i < 100; i++) begin
            if (mismatch) begin cnt++; if (first < 0) first = i; end
            tick();
        end
`ifdef SIMON_TIMEOUT_EN
        chk("timeout_cycle", first, 20);
        chk("timeout_pulses", cnt, 1);
`else
        chk("no_timeout_pulses", cnt, 0);
        chk("no_timeout_waiting", input_phase, 1);
`endif
        st = OVER; tick();
        chk("end_level", level, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
